spike_rate_decoder: RTL and testbench

Receive-side decoder for the 1-bit spike train produced by the adaptive LIF neuron core. It converts spikes back into numeric values: spike count per fixed window (rate code) and most recent inter-spike interval (temporal code). Each closed window yields one result word, delivered to downstream logic (readout mux, host debug port) over a valid/ready handshake.

---
 rtl/spike_rate_decoder.sv | 100 ++++++++++
 tb/tb_spike_rate_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Receive-side spike train decoder: per-window spike count (rate code) and
// most recent inter-spike interval (temporal code) behind a valid/ready handshake.
module spike_rate_decoder #(
    parameter int WIN_LOG2 = 6,
    parameter int CNT_W    = 8,
    parameter int ISI_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] rate_out,
    output logic [ISI_W-1:0] isi_out,
    output logic             overrun
);

    localparam logic [WIN_LOG2-1:0] WIN_ONE = WIN_LOG2'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [ISI_W-1:0]    ISI_ONE = ISI_W'(1);

    logic [WIN_LOG2-1:0] win_cnt;
    logic [CNT_W-1:0]    spike_cnt;
    logic [CNT_W-1:0]    win_total;
    logic [ISI_W-1:0]    isi_cnt;
    logic [ISI_W-1:0]    isi_last;
    logic [ISI_W-1:0]    isi_sat_inc;
    logic [ISI_W-1:0]    isi_last_nxt;
    logic                seen_spike;
    logic                spike_en;
    logic                close;
    logic                transfer;
    logic                load;

    // Window total and ISI include the current cycle's spike so the close-cycle
    // spike is attributed to the closing window.
    always_comb begin
        spike_en     = ena & spike_in;
        close        = ena & (win_cnt == '1);
        transfer     = out_valid & out_ready;
        load         = close & (~out_valid | out_ready);

        win_total = spike_cnt;
        if (spike_en && (spike_cnt != '1)) begin
            win_total = spike_cnt + CNT_ONE;
        end

        isi_sat_inc = isi_cnt;
        if (isi_cnt != '1) begin
            isi_sat_inc = isi_cnt + ISI_ONE;
        end

        isi_last_nxt = isi_last;
        if (spike_en && seen_spike) begin
            isi_last_nxt = isi_sat_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt    <= '0;
            spike_cnt  <= '0;
            isi_cnt    <= '0;
            isi_last   <= '0;
            seen_spike <= 1'b0;
            rate_out   <= '0;
            isi_out    <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (ena) begin
                win_cnt   <= win_cnt + WIN_ONE;
                spike_cnt <= close ? '0 : win_total;
                isi_last  <= isi_last_nxt;
                if (spike_in) begin
                    isi_cnt    <= '0;
                    seen_spike <= 1'b1;
                end else begin
                    isi_cnt <= isi_sat_inc;
                end
            end

            // A close with a held, unconsumed result drops the new one.
            if (load) begin
                rate_out  <= win_total;
                isi_out   <= isi_last_nxt;
                out_valid <= 1'b1;
            end else begin
                if (close) begin
                    overrun <= 1'b1;
                end
                if (transfer) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: default instance plus a long-window
// instance for count/ISI saturation.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, spike_in, out_ready;
    logic       out_valid, overrun;
    logic [7:0] rate_out, isi_out;

    logic       s_ena, s_spike, s_ready;
    logic       s_valid, s_overrun;
    logic [7:0] s_rate, s_isi;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WIN_LOG2(6), .CNT_W(8), .ISI_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
        .out_ready(out_ready), .out_valid(out_valid), .rate_out(rate_out),
        .isi_out(isi_out), .overrun(overrun)
    );

    spike_rate_decoder #(.WIN_LOG2(9), .CNT_W(8), .ISI_W(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(s_ena), .spike_in(s_spike),
        .out_ready(s_ready), .out_valid(s_valid), .rate_out(s_rate),
        .isi_out(s_isi), .overrun(s_overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; s_ena = 1'b0; s_spike = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; out_ready = 1'b1;
        s_ena = 1'b0; s_spike = 1'b0; s_ready = 1'b1;
        tick; tick;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_rate", rate_out, 0);
        check_eq("rst_isi", isi_out, 0);
        check_eq("rst_overrun", overrun, 0);

        // No spikes: 1-cycle pulse every 64 cycles
        rst_n = 1'b1; ena = 1'b1;
        repeat (63) tick;
        check_eq("idle_pre_close", out_valid, 0);
        tick;
        check_eq("idle_valid", out_valid, 1);
        check_eq("idle_rate", rate_out, 0);
        check_eq("idle_isi", isi_out, 0);
        tick;
        check_eq("idle_pulse_end", out_valid, 0);
        repeat (62) tick;
        check_eq("idle_pre_close2", out_valid, 0);
        tick;
        check_eq("idle_valid2", out_valid, 1);

        // Spike every 4th cycle
        do_reset;
        ena = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 128; t++) begin
            spike_in = (t % 4 == 0);
            tick;
            if (t == 63 || t == 127) begin
                check_eq("p4_valid", out_valid, 1);
                check_eq("p4_rate", rate_out, 16);
                check_eq("p4_isi", isi_out, 4);
            end
        end

        // Saturation on 512-cycle windows
        do_reset;
        s_ena = 1'b1;
        for (int t = 0; t < 1024; t++) begin
            s_spike = (t < 512) || (t == 512) || (t == 812);
            tick;
            if (t == 511) begin
                check_eq("sat_valid", s_valid, 1);
                check_eq("sat_rate", s_rate, 255);
                check_eq("sat_isi1", s_isi, 1);
            end
            if (t == 512) check_eq("sat_pulse_end", s_valid, 0);
            if (t == 1023) begin
                check_eq("sat_valid2", s_valid, 1);
                check_eq("sat_rate2", s_rate, 2);
                check_eq("sat_isi255", s_isi, 255);
            end
        end
        s_ena = 1'b0;

        // Overrun: 5 then 9 spikes with out_ready low
        do_reset;
        ena = 1'b1; out_ready = 1'b0;
        for (int t = 0; t < 128; t++) begin
            spike_in = (t < 5) || (t >= 64 && t <= 80 && (t % 2 == 0));
            tick;
            if (t == 63) begin
                check_eq("ovr_valid1", out_valid, 1);
                check_eq("ovr_rate1", rate_out, 5);
                check_eq("ovr_isi1", isi_out, 1);
                check_eq("ovr_not_yet", overrun, 0);
            end
        end
        check_eq("ovr_valid2", out_valid, 1);
        check_eq("ovr_rate_held", rate_out, 5);
        check_eq("ovr_isi_held", isi_out, 1);
        check_eq("ovr_flag", overrun, 1);
        spike_in = 1'b0; out_ready = 1'b1;
        tick;
        check_eq("ovr_drained", out_valid, 0);
        check_eq("ovr_sticky", overrun, 1);

        // ena low for 10 cycles mid-window, spikes ignored meanwhile
        do_reset;
        out_ready = 1'b1;
        for (int t = 0; t < 74; t++) begin
            int e;
            ena = !(t >= 20 && t < 30);
            e = (t < 20) ? t : t - 10;
            spike_in = ena ? (e == 0 || e == 10 || e == 40) : 1'b1;
            tick;
            if (t == 72) check_eq("ena_pre_close", out_valid, 0);
        end
        check_eq("ena_valid", out_valid, 1);
        check_eq("ena_rate", rate_out, 3);
        check_eq("ena_isi", isi_out, 30);
        ena = 1'b0; out_ready = 1'b0; spike_in = 1'b0;
        repeat (3) tick;
        check_eq("ena_hold", out_valid, 1);
        out_ready = 1'b1;
        tick;
        check_eq("ena_off_xfer", out_valid, 0);

        // Reset with pending result and overrun set
        do_reset;
        ena = 1'b1; out_ready = 1'b0; spike_in = 1'b1;
        repeat (158) tick;
        check_eq("mid_valid_pre", out_valid, 1);
        check_eq("mid_ovr_pre", overrun, 1);
        rst_n = 1'b0;
        tick;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_rate", rate_out, 0);
        check_eq("mid_rst_isi", isi_out, 0);
        check_eq("mid_rst_ovr", overrun, 0);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 64; t++) begin
            spike_in = (t == 0);
            tick;
            if (t == 62) check_eq("post_rst_pre", out_valid, 0);
        end
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_rate", rate_out, 1);
        check_eq("post_rst_isi", isi_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
